// File: rtl/out_bcd_display.sv
// out_bcd_display: converts the cpu output value to packed BCD with a
// sequential double-dabble engine (one bit per cycle) and scans the digits
// onto a multiplexed 7-segment display with leading-zero blanking.
// Optional feature macro: BCD_DISPLAY_SIGNED_EN (two's complement input,
// magnitude displayed and sign reported on neg).
module out_bcd_display #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DIGITS     = 5,
  parameter int unsigned SCAN_DIV   = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   in,
  output logic [4*DIGITS-1:0]     bcd,
  output logic                    neg,
  output logic                    valid,
  output logic                    busy,
  output logic [DIGITS-1:0]       an,
  output logic [6:0]              seg
);

  localparam int unsigned BCD_W  = 4 * DIGITS;
  localparam int unsigned CNT_W  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t                r_state;
  logic [BCD_W-1:0]      r_bcd;
  logic                  r_valid;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_last_val;
  logic                  r_force;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [BCD_W-1:0]      r_scratch;
  logic [CNT_W-1:0]      r_cnt;

  logic [SCAN_W-1:0]     r_scan_cnt;
  logic [DIG_W-1:0]      r_digit_idx;
  logic [DIGITS-1:0]     r_an;
  logic [6:0]            r_seg;

  logic [DATA_WIDTH-1:0] w_mag;
  logic [BCD_W-1:0]      w_adj;
  logic [DIG_W-1:0]      w_digit_next;
  logic [SCAN_W-1:0]     w_scan_next;
  logic [3:0]            w_sel_digit;
  logic                  w_blank;

`ifdef BCD_DISPLAY_SIGNED_EN
  logic w_sign;
  logic r_sign;
  logic r_neg;

  // Magnitude of a two's complement input; the most negative value wraps to its unsigned magnitude
  assign w_sign = in[DATA_WIDTH-1];
  assign w_mag  = w_sign ? DATA_WIDTH'(-in) : in;
  assign neg    = r_neg;
`else
  assign w_mag  = in;
  assign neg    = 1'b0;
`endif

  // Hex digit to active-high segments (bit0 = a ... bit6 = g)
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  // Double-dabble correction: every scratch digit >= 5 gets +3 before the shift
  always_comb begin
    w_adj = r_scratch;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (r_scratch[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_scratch[4*k +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM: IDLE watches the input, SHIFT runs the engine, DONE publishes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_bcd      <= '0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
      r_last_val <= '0;
      r_force    <= 1'b1;
      r_shift    <= '0;
      r_scratch  <= '0;
      r_cnt      <= '0;
`ifdef BCD_DISPLAY_SIGNED_EN
      r_sign     <= 1'b0;
      r_neg      <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if ((in != r_last_val) || r_force) begin
            r_last_val <= in;
            r_shift    <= w_mag;
            r_scratch  <= '0;
            r_cnt      <= '0;
            r_force    <= 1'b0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b1;
`ifdef BCD_DISPLAY_SIGNED_EN
            r_sign     <= w_sign;
`endif
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= BCD_W'({w_adj, r_shift[DATA_WIDTH-1]});
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_WIDTH - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_bcd   <= r_scratch;
          r_valid <= 1'b1;
          r_busy  <= 1'b0;
`ifdef BCD_DISPLAY_SIGNED_EN
          r_neg   <= r_sign;
`endif
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Next scan position: dwell SCAN_DIV cycles per digit, wrap after the last digit
  always_comb begin
    w_scan_next  = r_scan_cnt + SCAN_W'(1);
    w_digit_next = r_digit_idx;
    if (r_scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
      w_scan_next = '0;
      if (r_digit_idx == DIG_W'(DIGITS - 1)) begin
        w_digit_next = '0;
      end else begin
        w_digit_next = r_digit_idx + DIG_W'(1);
      end
    end
  end

  // Select the digit about to be lit and decide leading-zero blanking from published bcd
  always_comb begin
    w_sel_digit = r_bcd[3:0];
    w_blank     = 1'b0;
    for (int k = 1; k < int'(DIGITS); k++) begin
      if (w_digit_next == DIG_W'(k)) begin
        w_sel_digit = r_bcd[4*k +: 4];
        w_blank     = ((r_bcd >> (4 * k)) == '0);
      end
    end
  end

  // Display scanner: free-running, independent of the conversion FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= '0;
      r_an        <= DIGITS'(1);
      r_seg       <= 7'h3F;
    end else begin
      r_scan_cnt  <= w_scan_next;
      r_digit_idx <= w_digit_next;
      r_an        <= DIGITS'(1) << w_digit_next;
      r_seg       <= w_blank ? 7'h00 : seg_decode(w_sel_digit);
    end
  end

  assign bcd   = r_bcd;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign an    = r_an;
  assign seg   = r_seg;

endmodule

// File: tb/tb_out_bcd_display.sv
// Directed bench for out_bcd_display: conversion latency, auto-reconvert,
// equal-value rewrite, mid-conversion reset and digit scanning with blanking.
module tb_out_bcd_display;

  logic        clk;
  logic        rst_n;
  logic [15:0] in_val;
  logic [19:0] bcd;
  logic        neg;
  logic        valid;
  logic        busy;
  logic [4:0]  an;
  logic [6:0]  seg;

  int n_tests = 0;
  int n_fail  = 0;

  out_bcd_display #(
    .DATA_WIDTH(16),
    .DIGITS    (5),
    .SCAN_DIV  (16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in_val),
    .bcd  (bcd),
    .neg  (neg),
    .valid(valid),
    .busy (busy),
    .an   (an),
    .seg  (seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected segments for digit idx of a BCD value, with leading-zero blanking
  function automatic logic [6:0] exp_seg(input logic [19:0] v, input int idx);
    logic [6:0] tbl [10];
    logic [3:0] d;
    tbl[0] = 7'h3F; tbl[1] = 7'h06; tbl[2] = 7'h5B; tbl[3] = 7'h4F; tbl[4] = 7'h66;
    tbl[5] = 7'h6D; tbl[6] = 7'h7D; tbl[7] = 7'h07; tbl[8] = 7'h7F; tbl[9] = 7'h6F;
    if (idx > 0 && (v >> (4 * idx)) == 20'h0) return 7'h00;
    d = v[4*idx +: 4];
    return tbl[d];
  endfunction

  task automatic convert_check(input logic [15:0] v, input logic [19:0] eb, input logic en);
    in_val = v;
    tick();
    chk("busy_start", 32'(busy), 32'd1);
    repeat (16) tick();
    chk("busy_last", 32'(busy), 32'd1);
    chk("valid_low_busy", 32'(valid), 32'd0);
    tick();
    chk("valid_done", 32'(valid), 32'd1);
    chk("bcd_done", 32'(bcd), 32'(eb));
    chk("neg_done", 32'(neg), 32'(en));
    chk("busy_done", 32'(busy), 32'd0);
  endtask

  task automatic scan_check(input logic [19:0] eb);
    int lit [5];
    int idx;
    for (int k = 0; k < 5; k++) lit[k] = 0;
    repeat (2) tick();
    for (int c = 0; c < 80; c++) begin
      tick();
      idx = -1;
      for (int k = 0; k < 5; k++) if (an == (5'd1 << k)) idx = k;
      chk("scan_onehot", 32'($onehot(an)), 32'd1);
      if (idx >= 0) begin
        lit[idx]++;
        chk("scan_seg", 32'(seg), 32'(exp_seg(eb, idx)));
      end
    end
    for (int k = 0; k < 5; k++) chk("scan_dwell", 32'(lit[k]), 32'd16);
  endtask

  initial begin
    rst_n  = 1'b1;
    in_val = 16'd0;
    #3 rst_n = 1'b0;
    tick();
    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_an", 32'(an), 32'd1);
    chk("rst_seg", 32'(seg), 32'h3F);
    tick();
    rst_n = 1'b1;

    // 1: forced conversion of 0 after reset
    convert_check(16'd0, 20'h00000, 1'b0);
    scan_check(20'h00000);

    // 2: 1234 with digit 4 blanked
    convert_check(16'd1234, 20'h01234, 1'b0);
    scan_check(20'h01234);

    // 3: all ones
`ifdef BCD_DISPLAY_SIGNED_EN
    convert_check(16'hFFFF, 20'h00001, 1'b1);
    scan_check(20'h00001);
`else
    convert_check(16'hFFFF, 20'h65535, 1'b0);
    scan_check(20'h65535);
`endif

    // 4: input change during conversion is deferred, then reconverted
    in_val = 16'd100;
    tick();
    chk("t4_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    in_val = 16'd7;
    repeat (11) tick();
    chk("t4_busy_last", 32'(busy), 32'd1);
    tick();
    chk("t4_valid_first", 32'(valid), 32'd1);
    chk("t4_bcd_first", 32'(bcd), 32'h00100);
    tick();
    chk("t4_busy_again", 32'(busy), 32'd1);
    chk("t4_valid_low", 32'(valid), 32'd0);
    chk("t4_bcd_hold", 32'(bcd), 32'h00100);
    repeat (16) tick();
    chk("t4_valid_second_low", 32'(valid), 32'd0);
    tick();
    chk("t4_valid_second", 32'(valid), 32'd1);
    chk("t4_bcd_second", 32'(bcd), 32'h00007);
    chk("t4_busy_second", 32'(busy), 32'd0);

    // 5: same value rewritten does not reconvert
    convert_check(16'd42, 20'h00042, 1'b0);
    in_val = 16'd42;
    for (int c = 0; c < 40; c++) begin
      tick();
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_valid", 32'(valid), 32'd1);
    end

    // 6: reset mid-SHIFT aborts, then forced conversion of current input
    in_val = 16'd555;
    tick();
    chk("t6_busy", 32'(busy), 32'd1);
    repeat (5) tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_valid", 32'(valid), 32'd0);
    chk("t6_rst_bcd", 32'(bcd), 32'd0);
    chk("t6_rst_an", 32'(an), 32'd1);
    chk("t6_rst_seg", 32'(seg), 32'h3F);
    tick();
    chk("t6_rst_hold", 32'(busy), 32'd0);
    rst_n = 1'b1;
    convert_check(16'd555, 20'h00555, 1'b0);

`ifdef BCD_DISPLAY_SIGNED_EN
    convert_check(16'h8000, 20'h32768, 1'b1);
`else
    convert_check(16'h8000, 20'h32768, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
